// File: rtl/stopwatch_display.sv
// stopwatch_display: MM:SS stopwatch / countdown timer with a 4-digit
// multiplexed 7-segment driver. It has run/pause control, up/down counting,
// BCD preset load, lap freeze and countdown expiry.
module stopwatch_display #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int TICK_HZ        = 1,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic        lap,
  input  logic        mode,
  input  logic [15:0] preset,
  output logic [15:0] count_bcd,
  output logic        running,
  output logic        expired,
  output logic        lap_active,
  output logic [7:0]  seg,
  output logic [3:0]  anode
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int SW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXP} state_t;

  state_t        r_state, w_state_nx;
  logic [15:0]   r_cnt, w_cnt_nx;
  logic [15:0]   r_lapv, w_lapv_nx;
  logic          r_lap, w_lap_nx;
  logic [PW-1:0] r_presc, w_presc_nx;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_digit;
  logic [7:0]    r_seg;
  logic [3:0]    r_an;
  logic          w_tick, w_expire, w_preset_ok;
  logic [15:0]   w_disp;
  logic [3:0]    w_nib;
  logic [6:0]    w_dec;
  logic [7:0]    w_seg_raw;
  logic [3:0]    w_an_raw;

  // BCD +1 with carry through 9/5/9/5; 59:59 rolls over to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = (v[15:12] == 4'd5) ? 4'd0 : v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // BCD -1 with borrow; the caller never passes 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign w_preset_ok = (preset[3:0] <= 4'd9) && (preset[7:4] <= 4'd5) &&
                       (preset[11:8] <= 4'd9) && (preset[15:12] <= 4'd5);
  assign w_tick      = (r_state == S_RUN) && (r_presc == PRESC_MAX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next state and datapath: the tick is applied first, then the
  // highest-priority control pulse (clear > load > start_stop > lap).
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_presc_nx = r_presc;
    w_lap_nx   = r_lap;
    w_lapv_nx  = r_lapv;
    w_expire   = 1'b0;
    if (r_state == S_RUN) w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
    if (w_tick) begin
      if (!mode) w_cnt_nx = bcd_inc(r_cnt);
      else if (r_cnt != 16'h0000) begin
        w_cnt_nx = bcd_dec(r_cnt);
        if (r_cnt == 16'h0001) begin
          w_state_nx = S_EXP;
          w_expire   = 1'b1;
        end
      end
    end
    if (clear) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = 16'h0000;
      w_lap_nx   = 1'b0;
      w_presc_nx = '0;
    end else if (load && (r_state == S_IDLE || r_state == S_PAUSE)) begin
      if (w_preset_ok) w_cnt_nx = preset;
    end else if (start_stop) begin
      case (r_state)
        S_IDLE:  if (!(mode && r_cnt == 16'h0000)) begin
                   w_state_nx = S_RUN;
                   w_presc_nx = '0;
                 end
        // An expiring tick wins over a coincident pause request.
        S_RUN:   if (!w_expire) w_state_nx = S_PAUSE;
        S_PAUSE: w_state_nx = S_RUN;
        default: w_state_nx = S_IDLE;
      endcase
    end else if (lap && r_state == S_RUN) begin
      w_lap_nx = ~r_lap;
      if (!r_lap) w_lapv_nx = r_cnt;
    end
  end

  // Count, prescaler and lap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 16'h0000;
      r_presc <= '0;
      r_lap   <= 1'b0;
      r_lapv  <= 16'h0000;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_presc <= w_presc_nx;
      r_lap   <= w_lap_nx;
      r_lapv  <= w_lapv_nx;
    end
  end

  // Scan timer: digit walks 3,2,1,0 and wraps, one step per SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_digit    <= 2'd3;
    end else if (r_scan_cnt == SCAN_MAX) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit - 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_disp = r_lap ? r_lapv : r_cnt;

  // Select the nibble for the scanned digit and decode it (active-high A..G).
  always_comb begin
    w_nib = 4'd0;
    case (r_digit)
      2'd0: w_nib = w_disp[3:0];
      2'd1: w_nib = w_disp[7:4];
      2'd2: w_nib = w_disp[11:8];
      2'd3: w_nib = w_disp[15:12];
    endcase
    w_dec = 7'h00;
    case (w_nib)
      4'd0: w_dec = 7'h3F;
      4'd1: w_dec = 7'h06;
      4'd2: w_dec = 7'h5B;
      4'd3: w_dec = 7'h4F;
      4'd4: w_dec = 7'h66;
      4'd5: w_dec = 7'h6D;
      4'd6: w_dec = 7'h7D;
      4'd7: w_dec = 7'h07;
      4'd8: w_dec = 7'h7F;
      4'd9: w_dec = 7'h6F;
      default: w_dec = 7'h00;
    endcase
    // The DP after the minutes-units digit is the MM.SS separator.
    w_seg_raw = {(r_digit == 2'd2), w_dec};
    if (BLANK_LZ && r_digit == 2'd3 && w_nib == 4'd0) w_seg_raw = 8'h00;
    w_an_raw = 4'b0001 << r_digit;
  end

  // Output registers with the board polarity applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
      r_an  <= AN_ACTIVE_LOW ? 4'hF : 4'h0;
    end else begin
      r_seg <= SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
      r_an  <= AN_ACTIVE_LOW ? ~w_an_raw : w_an_raw;
    end
  end

  assign count_bcd  = r_cnt;
  assign running    = (r_state == S_RUN);
  assign expired    = (r_state == S_EXP);
  assign lap_active = r_lap;
  assign seg        = r_seg;
  assign anode      = r_an;

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: the directed scenarios plus random pulses,
// all compared every cycle against a seconds-based behavioural model.
module tb_stopwatch_display;
  localparam int SDIV = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic ss = 1'b0, cl = 1'b0, ld = 1'b0, lp = 1'b0, md = 1'b0;
  logic [15:0] pre = 16'h0000;
  logic [15:0] count_bcd;
  logic running, expired, lap_active;
  logic [7:0] seg;
  logic [3:0] anode;

  stopwatch_display #(
    .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(ss), .clear(cl), .load(ld), .lap(lp),
    .mode(md), .preset(pre), .count_bcd(count_bcd), .running(running),
    .expired(expired), .lap_active(lap_active), .seg(seg), .anode(anode)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  // Reference model: count held as plain seconds 0..3599.
  int m_st, m_sec, m_presc, m_lapv, m_k;
  bit m_lap;
  logic [7:0] m_seg;
  logic [3:0] m_an;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0] an_tab [8] = '{4'b0111, 4'b0111, 4'b1011, 4'b1011,
                             4'b1101, 4'b1101, 4'b1110, 4'b1110};
  logic [7:0] sg_tab [8] = '{8'hFF, 8'hFF, 8'h10, 8'h10,
                             8'hC0, 8'hC0, 8'h92, 8'h92};

  function automatic logic [15:0] sec2bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic int bcd2sec(input logic [15:0] b);
    return int'(b[15:12]) * 600 + int'(b[11:8]) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [15:0] b);
    return (b[3:0] <= 9) && (b[7:4] <= 5) && (b[11:8] <= 9) && (b[15:12] <= 5);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_sec = 0; m_presc = 0; m_lap = 0; m_lapv = 0; m_k = 0;
    m_seg = 8'hFF; m_an = 4'hF;
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_edge();
    int d, v, dig, nst, nsec, npr, nlapv;
    bit nlap, tick, expd;
    logic [7:0] raw;
    d = 3 - ((m_k / SDIV) % 4);
    v = m_lap ? m_lapv : m_sec;
    case (d)
      0: dig = v % 10;
      1: dig = (v % 60) / 10;
      2: dig = (v / 60) % 10;
      default: dig = v / 600;
    endcase
    if (d == 3 && dig == 0) raw = 8'h00;
    else raw = {(d == 2), segtab[dig]};
    m_seg = ~raw;
    m_an  = ~(4'(1 << d));
    nst = m_st; nsec = m_sec; npr = m_presc; nlap = m_lap; nlapv = m_lapv;
    tick = (m_st == M_RUN) && (m_presc == 9);
    expd = 0;
    if (m_st == M_RUN) npr = (m_presc + 1) % 10;
    if (tick) begin
      if (!md) nsec = (m_sec + 1) % 3600;
      else if (m_sec > 0) begin
        nsec = m_sec - 1;
        if (nsec == 0) begin nst = M_EXP; expd = 1; end
      end
    end
    if (cl) begin
      nst = M_IDLE; nsec = 0; nlap = 0; npr = 0;
    end else if (ld && (m_st == M_IDLE || m_st == M_PAUSE)) begin
      if (bcd_ok(pre)) nsec = bcd2sec(pre);
    end else if (ss) begin
      if (m_st == M_IDLE) begin
        if (!(md && m_sec == 0)) begin nst = M_RUN; npr = 0; end
      end else if (m_st == M_RUN) begin
        if (!expd) nst = M_PAUSE;
      end else if (m_st == M_PAUSE) nst = M_RUN;
      else nst = M_IDLE;
    end else if (lp && m_st == M_RUN) begin
      nlap = !m_lap;
      if (!m_lap) nlapv = m_sec;
    end
    m_st = nst; m_sec = nsec; m_presc = npr; m_lap = nlap; m_lapv = nlapv;
    m_k++;
  endtask

  task automatic cyc(input logic s, input logic c, input logic l, input logic p,
                     input logic [15:0] pv);
    ss = s; cl = c; ld = l; lp = p; pre = pv;
    @(posedge clk);
    model_edge();
    #1;
    ss = 1'b0; cl = 1'b0; ld = 1'b0; lp = 1'b0;
    chk("count", count_bcd, sec2bcd(m_sec));
    chk("running", running, m_st == M_RUN);
    chk("expired", expired, m_st == M_EXP);
    chk("lap_active", lap_active, m_lap);
    chk("seg", seg, m_seg);
    chk("anode", anode, m_an);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, pre);
  endtask

  task automatic wait_cnt(input logic [15:0] v, input int bound, input string tag);
    for (int i = 0; i < bound && count_bcd !== v; i++) idle(1);
    chk(tag, count_bcd, v);
  endtask

  task automatic wait_an(input logic [3:0] a, input int bound, input string tag);
    for (int i = 0; i < bound && anode !== a; i++) idle(1);
    chk(tag, anode, a);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic s, c, l, p;
    logic [15:0] pv;
    model_reset();
    #12;
    chk("rst_count", count_bcd, 16'h0000);
    chk("rst_running", running, 1'b0);
    chk("rst_expired", expired, 1'b0);
    chk("rst_lap", lap_active, 1'b0);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_anode", anode, 4'hF);
    @(negedge clk); rst = 1'b0;

    // Up count and first-tick latency.
    md = 1'b0;
    cyc(1, 0, 0, 0, 16'h0000); chk("t1_run", running, 1'b1);
    idle(9);  chk("t1_c10", count_bcd, 16'h0000);
    idle(1);  chk("t1_c11", count_bcd, 16'h0001);
    idle(90); chk("t1_10tick", count_bcd, 16'h0010);

    // Up wrap from 59:58.
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'h5958); chk("t2_load", count_bcd, 16'h5958);
    cyc(1, 0, 0, 0, 16'h5958); idle(20);
    chk("t2_wrap", count_bcd, 16'h0000);
    chk("t2_run", running, 1'b1);
    chk("t2_noexp", expired, 1'b0);

    // Countdown and expiry.
    cyc(0, 1, 0, 0, 16'h0000); md = 1'b1;
    cyc(0, 0, 1, 0, 16'h0100);
    cyc(1, 0, 0, 0, 16'h0100); idle(10);
    chk("t3_borrow", count_bcd, 16'h0059);
    cyc(1, 0, 0, 0, 16'h0100); chk("t3_pause", running, 1'b0);
    cyc(0, 0, 1, 0, 16'h0002); chk("t3_load", count_bcd, 16'h0002);
    cyc(1, 0, 0, 0, 16'h0002);
    for (int i = 0; i < 40 && !expired; i++) idle(1);
    chk("t3_exp", expired, 1'b1);
    chk("t3_zero", count_bcd, 16'h0000);
    chk("t3_stop", running, 1'b0);
    idle(50);
    chk("t3_exp_hold", expired, 1'b1);
    chk("t3_zero_hold", count_bcd, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0002); chk("t3_ack", expired, 1'b0);
    cyc(1, 0, 0, 0, 16'h0002); chk("t3_norun0", running, 1'b0);

    // Pause keeps the fractional second; bad preset is rejected.
    cyc(0, 1, 0, 0, 16'h0000); md = 1'b0;
    cyc(1, 0, 0, 0, 16'h0000); idle(4);
    cyc(1, 0, 0, 0, 16'h0000); chk("t4_paused", running, 1'b0);
    idle(100); chk("t4_hold", count_bcd, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    n = 0;
    while (count_bcd == 16'h0000 && n < 20) begin idle(1); n++; end
    chk("t4_frac", n, 5);
    cyc(1, 0, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'h0A00); chk("t4_reject", count_bcd, 16'h0001);

    // Lap freeze and release.
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    wait_cnt(16'h0003, 40, "t5_reach3");
    cyc(0, 0, 0, 1, 16'h0000); chk("t5_lap_on", lap_active, 1'b1);
    wait_cnt(16'h0004, 20, "t5_reach4");
    wait_an(4'b1110, 10, "t5_an0");
    chk("t5_frozen", seg, 8'hB0);
    wait_cnt(16'h0005, 20, "t5_reach5");
    cyc(0, 0, 0, 1, 16'h0000); chk("t5_lap_off", lap_active, 1'b0);
    idle(1);
    wait_an(4'b1110, 10, "t5_an0b");
    chk("t5_live", seg, 8'h92);
    cyc(1, 1, 0, 0, 16'h0000);
    chk("t5_clr_run", running, 1'b0);
    chk("t5_clr_cnt", count_bcd, 16'h0000);

    // Scan order and decode of 09.05.
    cyc(0, 0, 1, 0, 16'h0905); idle(2);
    wait_an(4'b1110, 10, "t6_sync0");
    wait_an(4'b0111, 10, "t6_sync3");
    for (int i = 0; i < 8; i++) begin
      chk("t6_anode", anode, an_tab[i]);
      chk("t6_seg", seg, sg_tab[i]);
      idle(1);
    end

    // Asynchronous reset in mid-count.
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000); idle(15);
    #2 rst = 1'b1;
    #1;
    chk("ar_count", count_bcd, 16'h0000);
    chk("ar_running", running, 1'b0);
    chk("ar_seg", seg, 8'hFF);
    chk("ar_anode", anode, 4'hF);
    @(negedge clk); rst = 1'b0; model_reset();

    // Random pulses against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) == 0) md = ~md;
      s = ($urandom_range(29) == 0);
      c = ($urandom_range(299) == 0);
      l = ($urandom_range(39) == 0);
      p = ($urandom_range(24) == 0);
      case ($urandom_range(3))
        0: pv = sec2bcd(int'($urandom_range(3599)));
        1: pv = sec2bcd(int'($urandom_range(5)));
        2: pv = sec2bcd(3595 + int'($urandom_range(4)));
        default: pv = 16'($urandom);
      endcase
      cyc(s, c, l, p, pv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
